reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 32: consecutive synchronized-lock cycles required before reset hold begins (legal range 2..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles proj_rst_n is held low before release (legal range 2..65535).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4096: stable cycles required for a button state change (legal range 2..65535).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port pll_locked, input, 1: asynchronous PLL lock indication.
REQ-007 SHALL have port btn_n, input, 1: asynchronous user reset button, active-low (0 = pressed).
REQ-008 SHALL have port proj_rst_n, output, 1: active-low reset to the user project, driven directly from a flop.
REQ-009 SHALL have port proj_ena, output, 1: project enable, driven directly from a flop.
REQ-010 SHALL have port seq_state, output, 3: current state encoding (WAIT_LOCK=0, LOCK_STABLE=1, HOLD=2, RUN=3, BTN_RESET=4).
REQ-011 SHALL have port lock_loss_cnt, output, 4: saturating count of lock losses.

Function
REQ-012 SHALL pass pll_locked through a 2-flop synchronizer (lock_s) and btn_n through a 2-flop synchronizer (btn_s); the FSM samples only the synchronized values.
REQ-013 WAIT_LOCK: on lock_s=1, go to LOCK_STABLE with the cycle counter cleared.
REQ-014 LOCK_STABLE: counter increments each cycle; after exactly LOCK_CYCLES cycles in this state, go to HOLD with the counter cleared; lock_s=0 returns to WAIT_LOCK with lock_loss_cnt unchanged.
REQ-015 HOLD: after exactly HOLD_CYCLES cycles, go to RUN.
REQ-016 RUN: a debounced press goes to BTN_RESET.
REQ-017 BTN_RESET: remain while the debounced button is pressed; on debounced release, go to HOLD with the counter cleared.
REQ-018 lock_s=0 in HOLD, RUN or BTN_RESET SHALL go to WAIT_LOCK and increment lock_loss_cnt, saturating at 15.
REQ-019 lock loss SHALL take priority over a simultaneous button event.
REQ-020 proj_rst_n SHALL be 1 exactly while the state register is RUN, updating on the same edge as the state.
REQ-021 proj_ena SHALL be 1 while in HOLD, RUN or BTN_RESET, and 0 in WAIT_LOCK and LOCK_STABLE.
REQ-022 Debouncer: the debounced value SHALL take btn_s only after btn_s has differed from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match clears the count.
REQ-023 Counter width SHALL be 16 bits; counters SHALL never wrap within the legal parameter range.

Reset
REQ-024 On rst=1 at an edge: state=WAIT_LOCK, all counters=0, lock synchronizer=0, button synchronizer and debounced value=1 (released), proj_rst_n=0, proj_ena=0, lock_loss_cnt=0.
REQ-025 rst SHALL override every other input in any state, including mid-count.

Configuration
REQ-026 Macro RESET_SEQ_DEBOUNCE_EN, when defined, SHALL include the REQ-022 debouncer.
REQ-027 When RESET_SEQ_DEBOUNCE_EN is not defined, the FSM SHALL use btn_s directly as the debounced value, DEBOUNCE_CYCLES SHALL be ignored, and no debounce counter SHALL exist.

Verification (LOCK_CYCLES=32, HOLD_CYCLES=16, DEBOUNCE_CYCLES=8; macro defined unless stated)
REQ-028 Release rst, then pll_locked=1 before edge 0 -> seq_state=1 at edge 2, 2 at edge 34, 3 at edge 50; proj_rst_n rises at edge 50; proj_ena rises at edge 34.
REQ-029 pll_locked low for 1 cycle while in LOCK_STABLE -> return to WAIT_LOCK, full 32-cycle restart, lock_loss_cnt stays 0.
REQ-030 pll_locked drops in RUN -> seq_state=0 and proj_rst_n=0 at the 3rd edge after the drop, lock_loss_cnt=1; 16 such drops -> lock_loss_cnt=15 (saturated).
REQ-031 In RUN, btn_n low for 5 cycles -> no state change; btn_n low for 20 cycles -> BTN_RESET 11 edges after press; release -> HOLD 11 edges after release, then RUN 16 edges later.
REQ-032 In RUN, btn_n low and pll_locked low in the same cycle -> WAIT_LOCK, never BTN_RESET, lock_loss_cnt incremented.
REQ-033 rst=1 for one edge while in HOLD mid-count -> all outputs at REQ-024 values after that edge; with the macro undefined, a 1-cycle btn_n pulse in RUN -> BTN_RESET 3 edges later.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / lock-driven reset sequencer for a user project: waits for a stable PLL lock, holds reset, then runs.
// Optional button debouncer is included when RESET_SEQ_DEBOUNCE_EN is defined; otherwise the synchronized button is used directly.
module reset_sequencer #(
  parameter int unsigned LOCK_CYCLES     = 32,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       btn_n,
  output logic       proj_rst_n,
  output logic       proj_ena,
  output logic [2:0] seq_state,
  output logic [3:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    HOLD        = 3'd2,
    RUN         = 3'd3,
    BTN_RESET   = 3'd4
  } state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  // Reject out-of-range configurations at elaboration time.
  if (LOCK_CYCLES < 2 || LOCK_CYCLES > 65535) begin : g_bad_lock
    $error("LOCK_CYCLES out of range 2..65535");
  end
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 2..65535");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES out of range 2..65535");
  end

  logic lock_s1_q, lock_s_q;
  logic btn_s1_q, btn_s_q;
  logic btn_deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
      btn_s1_q  <= 1'b1;
      btn_s_q   <= 1'b1;
    end else begin
      lock_s1_q <= pll_locked;
      lock_s_q  <= lock_s1_q;
      btn_s1_q  <= btn_n;
      btn_s_q   <= btn_s1_q;
    end
  end

`ifdef RESET_SEQ_DEBOUNCE_EN
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        btn_deb_q, btn_deb_d;

  // Count consecutive disagreement; any agreement restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    if (btn_s_q != btn_deb_q) begin
      if (deb_cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
        btn_deb_d = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      btn_deb_q <= 1'b1;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      btn_deb_q <= btn_deb_d;
    end
  end

  assign btn_deb = btn_deb_q;
`else
  assign btn_deb = btn_s_q;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  llc_q, llc_d, llc_inc;
  logic        proj_rst_n_q, proj_ena_q;

  assign llc_inc = (llc_q == 4'hF) ? llc_q : llc_q + 4'd1;

  // Lock loss is checked first in every post-lock state so it wins over button events.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    llc_d   = llc_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) state_d = LOCK_STABLE;
      end
      LOCK_STABLE: begin
        if (!lock_s_q)               state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = HOLD;
        else                         cnt_d   = cnt_q + 16'd1;
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          llc_d   = llc_inc;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          llc_d   = llc_inc;
        end else if (!btn_deb) begin
          state_d = BTN_RESET;
        end
      end
      BTN_RESET: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          llc_d   = llc_inc;
        end else if (btn_deb) begin
          state_d = HOLD;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      llc_q        <= '0;
      proj_rst_n_q <= 1'b0;
      proj_ena_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      llc_q        <= llc_d;
      proj_rst_n_q <= (state_d == RUN);
      proj_ena_q   <= (state_d == HOLD) || (state_d == RUN) || (state_d == BTN_RESET);
    end
  end

  assign proj_rst_n    = proj_rst_n_q;
  assign proj_ena      = proj_ena_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_CYCLES=32, HOLD_CYCLES=16, DEBOUNCE_CYCLES=8.
// Button timing expectations follow whether RESET_SEQ_DEBOUNCE_EN is defined for the build.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       btn_n;
  logic       proj_rst_n;
  logic       proj_ena;
  logic [2:0] seq_state;
  logic [3:0] lock_loss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_llc = 0;

  reset_sequencer #(
    .LOCK_CYCLES    (32),
    .HOLD_CYCLES    (16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .btn_n        (btn_n),
    .proj_rst_n   (proj_rst_n),
    .proj_ena     (proj_ena),
    .seq_state    (seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // driver tasks: advance n rising edges, then sample 1 time unit later
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (seq_state == exp) break;
      tick(1);
    end
    check_eq(tag, 16'(seq_state), 16'(exp));
  endtask

  task automatic check_outputs(input string tag, input int st, input int rn, input int en, input int llc);
    check_eq({tag, ".state"}, 16'(seq_state), 16'(st));
    check_eq({tag, ".rst_n"}, 16'(proj_rst_n), 16'(rn));
    check_eq({tag, ".ena"},   16'(proj_ena), 16'(en));
    check_eq({tag, ".llc"},   16'(lock_loss_cnt), 16'(llc));
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    btn_n = 1'b1;
    tick(3);
    check_outputs("reset", 0, 0, 0, 0);

    // Bring-up timing from rst release; edge 0 is the first edge after release.
    rst = 1'b0;
    pll_locked = 1'b1;
    tick(2);                          // edge 1
    check_eq("up.e1.state", 16'(seq_state), 16'd0);
    tick(1);                          // edge 2
    check_outputs("up.e2", 1, 0, 0, 0);
    tick(31);                         // edge 33
    check_outputs("up.e33", 1, 0, 0, 0);
    tick(1);                          // edge 34
    check_outputs("up.e34", 2, 0, 1, 0);
    tick(15);                         // edge 49
    check_outputs("up.e49", 2, 0, 1, 0);
    tick(1);                          // edge 50
    check_outputs("up.e50", 3, 1, 1, 0);

    // Single-cycle lock glitch during LOCK_STABLE restarts the full lock window.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_state("glitch.reach_ls", 3'd1, 8);
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    check_outputs("glitch.wait", 0, 0, 0, 0);
    tick(1);
    check_eq("glitch.restart", 16'(seq_state), 16'd1);
    tick(31);
    check_eq("glitch.still_ls", 16'(seq_state), 16'd1);
    tick(1);
    check_outputs("glitch.hold", 2, 0, 1, 0);
    wait_state("glitch.run", 3'd3, 20);

`ifdef RESET_SEQ_DEBOUNCE_EN
    // Short presses separated by a release never accumulate.
    btn_n = 1'b0; tick(5);
    btn_n = 1'b1; tick(2);
    btn_n = 1'b0; tick(5);
    btn_n = 1'b1; tick(20);
    check_eq("btn.short", 16'(seq_state), 16'd3);

    btn_n = 1'b0;
    tick(10);
    check_eq("btn.press_e10", 16'(seq_state), 16'd3);
    tick(1);
    check_outputs("btn.press_e11", 4, 0, 1, 0);
    tick(9);
    btn_n = 1'b1;
    tick(10);
    check_eq("btn.rel_e10", 16'(seq_state), 16'd4);
    tick(1);
    check_outputs("btn.rel_e11", 2, 0, 1, 0);
    tick(15);
    check_eq("btn.rel_e26", 16'(seq_state), 16'd2);
    tick(1);
    check_outputs("btn.rel_e27", 3, 1, 1, 0);
`else
    // Without the debouncer a single-cycle pulse is honoured.
    btn_n = 1'b0;
    tick(1);
    btn_n = 1'b1;
    tick(1);
    check_eq("btn.pulse_e2", 16'(seq_state), 16'd3);
    tick(1);
    check_outputs("btn.pulse_e3", 4, 0, 1, 0);
    tick(1);
    check_outputs("btn.pulse_e4", 2, 0, 1, 0);
    tick(15);
    check_eq("btn.pulse_e19", 16'(seq_state), 16'd2);
    tick(1);
    check_outputs("btn.pulse_e20", 3, 1, 1, 0);
`endif

    // Simultaneous button press and lock loss: lock loss wins.
    btn_n = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    check_eq("prio.e2", 16'(seq_state), 16'd3);
    tick(1);
    exp_llc = sat_inc(exp_llc);
    check_outputs("prio.e3", 0, 0, 0, exp_llc);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_eq("prio.no_btn_reset", 16'(seq_state == 3'd4), 16'd0);
    end
    btn_n = 1'b1;
    pll_locked = 1'b1;
    wait_state("prio.recover", 3'd3, 80);

    // Lock loss in RUN: visible at the third edge after the drop.
    pll_locked = 1'b0;
    tick(2);
    check_eq("loss.e2", 16'(seq_state), 16'd3);
    tick(1);
    exp_llc = sat_inc(exp_llc);
    check_outputs("loss.e3", 0, 0, 0, exp_llc);

    // Repeated losses from HOLD until the counter saturates.
    for (int i = 0; i < 15; i++) begin
      pll_locked = 1'b1;
      wait_state("sat.reach_hold", 3'd2, 60);
      pll_locked = 1'b0;
      tick(3);
      exp_llc = sat_inc(exp_llc);
      check_eq("sat.llc", 16'(lock_loss_cnt), 16'(exp_llc));
    end
    check_eq("sat.final", 16'(lock_loss_cnt), 16'd15);

    // Synchronous reset mid-HOLD clears everything including the lock synchronizer.
    pll_locked = 1'b1;
    wait_state("rst.reach_hold", 3'd2, 60);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_outputs("rst.hold", 0, 0, 0, 0);
    tick(2);
    check_eq("rst.sync_e2", 16'(seq_state), 16'd0);
    tick(1);
    check_eq("rst.sync_e3", 16'(seq_state), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
